// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// Digit data, decimal points and mask are double-buffered into shadow registers
// that change only at frame boundaries (or on enable), so a frame never tears.
// Each digit slot is a blank dead-time followed by a drive window; all pins are
// registered.
// Optional feature macro: SEG7_PWM_DIM_EN adds a 4-bit brightness input that
// shortens the active part of each drive window.
module seg7_scan_ctrl #(
  parameter int unsigned SLOT_CYCLES  = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] digit_data,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_mask,
  input  logic        load,
`ifdef SEG7_PWM_DIM_EN
  input  logic [3:0]  brightness,
`endif
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_done,
  output logic        busy
);

  localparam int unsigned CW           = $clog2(SLOT_CYCLES);
  localparam int unsigned DRIVE_CYCLES = SLOT_CYCLES - BLANK_CYCLES;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_CYCLES - 1);
  localparam logic          POL        = ACTIVE_LOW;

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic [15:0]   data_q;
  logic [3:0]    dp_q;
  logic [3:0]    mask_q;
  logic          copy;
  logic          boundary;
  logic          drive_on;
  logic [3:0]    an_act;
  logic [6:0]    seg_act;
  logic          dp_act;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex digit
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Next-state, slot counter, shadow-copy and pending-load decisions
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    copy      = 1'b0;
    boundary  = 1'b0;
    if (!enable) begin
      // Disabling never counts as a frame boundary; a pending load survives
      state_d = StIdle;
      idx_d   = '0;
      cnt_d   = '0;
      if (load) pending_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          idx_d   = '0;
          cnt_d   = '0;
          copy    = 1'b1;
        end
        StBlank: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = StDrive;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDrive: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d  = StBlank;
            cnt_d    = '0;
            idx_d    = idx_q + 2'd1;
            boundary = (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
      if (boundary) begin
        if (pending_q || load) copy = 1'b1;
      end else if (state_q != StIdle && load) begin
        pending_d = 1'b1;
      end
      if (copy) pending_d = 1'b0;
    end
  end

  // Sequencer state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  // Shadow copy of the register-file contents
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      dp_q   <= '0;
      mask_q <= '0;
    end else if (copy) begin
      data_q <= digit_data;
      dp_q   <= dp_in;
      mask_q <= digit_mask;
    end
  end

`ifdef SEG7_PWM_DIM_EN
  logic [3:0]  bright_q;
  logic [20:0] pwm_thr;

  // Brightness is latched as each slot begins so a window never changes mid-slot
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bright_q <= 4'hF;
    end else if (state_d == StBlank && state_q != StBlank) begin
      bright_q <= brightness;
    end
  end

  // Length of the lit part of the drive window
  always_comb begin
    pwm_thr = ((21'(bright_q) + 21'd1) * 21'(DRIVE_CYCLES)) >> 4;
  end
`endif

  // Active-high pin values for the current state; enable gates them immediately
  always_comb begin
    drive_on = enable && (state_q == StDrive) && mask_q[idx_q];
`ifdef SEG7_PWM_DIM_EN
    drive_on = drive_on && (21'(cnt_q) < pwm_thr);
`endif
    an_act  = drive_on ? (4'b0001 << idx_q) : 4'b0000;
    seg_act = drive_on ? hex7(data_q[{idx_q, 2'b00} +: 4]) : 7'h00;
    dp_act  = drive_on & dp_q[idx_q];
  end

  // Registered, polarity-adjusted pins and status flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an_n       <= {4{POL}};
      seg_n      <= {7{POL}};
      dp_n       <= POL;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      an_n       <= an_act ^ {4{POL}};
      seg_n      <= seg_act ^ {7{POL}};
      dp_n       <= dp_act ^ POL;
      frame_done <= boundary;
      busy       <= enable && (state_q != StIdle);
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (SLOT_CYCLES=20, BLANK_CYCLES=4, active-low).
// The reference model tracks the scan as a position within the frame and derives
// slot, blank/drive phase and digit from plain arithmetic on that position.
module tb_seg7_scan_ctrl;

  localparam int unsigned SLOT  = 20;
  localparam int unsigned BLANK = 4;
  localparam int unsigned FRAME = 4 * SLOT;
  localparam logic [13:0] INACT = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] digit_data;
  logic [3:0]  dp_in;
  logic [3:0]  digit_mask;
  logic        load;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_done;
  logic        busy;

  always #5 clock = ~clock;

  seg7_scan_ctrl #(
    .SLOT_CYCLES (SLOT),
    .BLANK_CYCLES(BLANK),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .digit_data(digit_data),
    .dp_in     (dp_in),
    .digit_mask(digit_mask),
    .load      (load),
    .an_n      (an_n),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .frame_done(frame_done),
    .busy      (busy)
  );

  logic [13:0] sb[$];
  logic [13:0] mon_want;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state
  bit          m_run;
  bit          m_pend;
  int unsigned m_pos;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic [3:0]  m_mask;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] tbl[16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tbl[v];
  endfunction

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0t got an=%h seg=%h dp=%b fd=%b busy=%b want an=%h seg=%h dp=%b fd=%b busy=%b",
               name, $time, got[13:10], got[9:3], got[2], got[1], got[0],
               want[13:10], want[9:3], want[2], want[1], want[0]);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_pend = 1'b0;
    m_pos  = 0;
    m_data = '0;
    m_dp   = '0;
    m_mask = '0;
  endtask

  // Predict pins after the coming edge from current inputs, then advance the model
  task automatic model_step();
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        fd;
    logic        bsy;
    int unsigned s;
    int unsigned off;
    an  = 4'hF;
    seg = 7'h7F;
    dp  = 1'b1;
    s   = m_pos / SLOT;
    off = m_pos % SLOT;
    if (enable && m_run && off >= BLANK && m_mask[s]) begin
      an  = ~(4'b0001 << s);
      seg = ~hex7(m_data[4*s +: 4]);
      dp  = ~m_dp[s];
    end
    fd  = enable && m_run && (m_pos == FRAME - 1);
    bsy = enable && m_run;
    sb.push_back({an, seg, dp, fd, bsy});
    if (!enable) begin
      m_run = 1'b0;
      m_pos = 0;
      if (load) m_pend = 1'b1;
    end else if (!m_run) begin
      m_run  = 1'b1;
      m_pos  = 0;
      m_data = digit_data;
      m_dp   = dp_in;
      m_mask = digit_mask;
      m_pend = 1'b0;
    end else if (m_pos == FRAME - 1) begin
      if (m_pend || load) begin
        m_data = digit_data;
        m_dp   = dp_in;
        m_mask = digit_mask;
        m_pend = 1'b0;
      end
      m_pos = 0;
    end else begin
      m_pos++;
      if (load) m_pend = 1'b1;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge per cycle
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge clock);
    end
  endtask

  task automatic pulse_load(input logic [15:0] d);
    digit_data = d;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic wait_pos(input int unsigned slot, input int unsigned off);
    int k = 0;
    while (!(m_run && m_pos == slot * SLOT + off) && k < 400) begin
      step(1);
      k++;
    end
    if (k >= 400) begin
      n_checks++;
      $display("FAIL wait_pos timeout slot=%0d off=%0d", slot, off);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    check("async_reset", {an_n, seg_n, dp_n, frame_done, busy}, INACT);
    model_reset();
    sb.push_back(INACT);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Monitor: one expected pin vector per clock edge
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        mon_want = sb.pop_front();
        check("pins", {an_n, seg_n, dp_n, frame_done, busy}, mon_want);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    load       = 1'b0;
    digit_data = '0;
    dp_in      = '0;
    digit_mask = '0;
    model_reset();
    @(negedge clock);
    check("reset_state", {an_n, seg_n, dp_n, frame_done, busy}, INACT);
    reset = 1'b0;
    step(50);

    // Basic scan of 4321 with the decimal point on digit 2
    digit_data = 16'h4321;
    digit_mask = 4'hF;
    dp_in      = 4'b0100;
    enable     = 1'b1;
    step(2 * FRAME + 1);

    // Mid-frame load must not tear the current frame
    wait_pos(1, 10);
    pulse_load(16'hABCD);
    step(2 * FRAME);

    // Partial mask
    digit_mask = 4'b1010;
    pulse_load(16'hABCD);
    step(2 * FRAME);

    // Several loads before a boundary; the latest inputs win
    digit_mask = 4'hF;
    pulse_load(16'h1234);
    step(5);
    dp_in = 4'b1001;
    pulse_load(16'h5678);
    step(2 * FRAME);

    // Load arriving exactly on the boundary cycle
    wait_pos(3, SLOT - 1);
    pulse_load(16'h9EF0);
    step(FRAME);

    // Enable drop during digit 2's drive window, then re-enable
    wait_pos(2, BLANK + 5);
    enable = 1'b0;
    step(6);
    enable = 1'b1;
    step(FRAME + 10);

    // Randomised traffic: loads, unlatched data changes, enable drops
    for (int i = 0; i < 800; i++) begin
      if (!enable) enable = ($urandom_range(0, 3) == 0);
      else         enable = ($urandom_range(0, 149) != 0);
      load = ($urandom_range(0, 15) == 0);
      if (load || $urandom_range(0, 7) == 0) begin
        digit_data = 16'($urandom);
        dp_in      = 4'($urandom);
        digit_mask = 4'($urandom);
      end
      step(1);
    end
    load   = 1'b0;
    enable = 1'b1;
    step(FRAME);

    // Asynchronous reset in the middle of a drive window
    digit_mask = 4'hF;
    wait_pos(1, BLANK + 3);
    do_reset();
    step(20);
    enable = 1'b1;
    step(FRAME + 5);

    @(posedge clock);
    #2;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_drain got %0d entries left want 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
